// File: rtl/forthsuper_pkg.sv
// Shared Forth-core types: data-stack primitives, stack-memory bus ops,
// TOS-cache FSM states and the per-primitive need/delta table.
package forthsuper_pkg;

  typedef enum logic [3:0] {
    DS_NOP  = 4'd0,
    DS_LIT  = 4'd1,
    DS_DUP  = 4'd2,
    DS_DROP = 4'd3,
    DS_SWAP = 4'd4,
    DS_OVER = 4'd5,
    DS_ROT  = 4'd6,
    DS_ADD  = 4'd7,
    DS_SUB  = 4'd8,
    DS_AND  = 4'd9
  } ds_op_t;

  typedef enum logic [1:0] {
    SS_NOP  = 2'd0,
    SS_PUSH = 2'd1,
    SS_POP  = 2'd2
  } stack_ops;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_ROT_W = 2'd2,
    ST_ROT_P = 2'd3
  } ds_state_t;

  // Minimum number of stack items a primitive consumes.
  function automatic logic [1:0] ds_need(input ds_op_t op);
    case (op)
      DS_DUP, DS_DROP:                         ds_need = 2'd1;
      DS_SWAP, DS_OVER, DS_ADD, DS_SUB, DS_AND: ds_need = 2'd2;
      DS_ROT:                                  ds_need = 2'd3;
      default:                                 ds_need = 2'd0;
    endcase
  endfunction

  // Net change in item count: +1, 0 or -1.
  function automatic logic signed [1:0] ds_delta(input ds_op_t op);
    case (op)
      DS_LIT, DS_DUP, DS_OVER:         ds_delta = 2'sb01;
      DS_DROP, DS_ADD, DS_SUB, DS_AND: ds_delta = 2'sb11;
      default:                         ds_delta = 2'sb00;
    endcase
  endfunction

endpackage

// File: rtl/ds_tos_cache.sv
// Forth data-stack front end: caches TOS/NOS in registers and drives the
// PUSH/POP/NOP bus of the stack memory holding the 3rd item downward.
// Ports:
//   clk, rst               clock, async active-high reset
//   cmd_valid/ready        one primitive per handshake (cmd_op, cmd_val)
//   tos, nos, depth        cached top two items and total item count
//   err_under, err_over    1-cycle pulses for rejected primitives
//   ss_op, ss_vi, ss_s     stack-memory op, push data, popped data
module ds_tos_cache
  import forthsuper_pkg::*;
#(
  parameter int unsigned DSZ    = 32,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  ds_op_t                       cmd_op,
  input  logic [DSZ-1:0]               cmd_val,
  output logic [DSZ-1:0]               tos,
  output logic [DSZ-1:0]               nos,
  output logic [$clog2(DEPTH+3)-1:0]   depth,
  output logic                         err_under,
  output logic                         err_over,
  output stack_ops                     ss_op,
  output logic [DSZ-1:0]               ss_vi,
  input  logic [DSZ-1:0]               ss_s
);

  localparam int unsigned DW = $clog2(DEPTH + 3);
  localparam int unsigned LW = 2;
  localparam logic [DW-1:0] FULL = DW'(DEPTH + 2);

  ds_state_t         state_q, state_d;
  logic [LW-1:0]     lat_q, lat_d;
  logic [DSZ-1:0]    tos_d, nos_d, ss_vi_d, alu_c;
  logic [DW-1:0]     depth_d;
  logic              ready_d, under_d, over_d;
  stack_ops          ss_op_d;
  logic              data_rdy_c;

  // Popped value is on ss_s once the latency counter reaches RD_LAT.
  assign data_rdy_c = (lat_q == LW'(RD_LAT));

  // DROP passes NOS through; ALU ops combine NOS with TOS.
  always_comb begin
    case (cmd_op)
      DS_ADD:  alu_c = nos + tos;
      DS_SUB:  alu_c = nos - tos;
      DS_AND:  alu_c = nos & tos;
      default: alu_c = nos;
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    tos_d   = tos;
    nos_d   = nos;
    depth_d = depth;
    ready_d = cmd_ready;
    ss_op_d = SS_NOP;
    ss_vi_d = ss_vi;
    under_d = 1'b0;
    over_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (DW'(ds_need(cmd_op)) > depth) begin
            under_d = 1'b1;
          end else if ((ds_delta(cmd_op) == 2'sb01) && (depth == FULL)) begin
            over_d = 1'b1;
          end else begin
            if (ds_delta(cmd_op) == 2'sb01) depth_d = depth + DW'(1);
            else if (ds_delta(cmd_op) == 2'sb11) depth_d = depth - DW'(1);

            case (cmd_op)
              DS_LIT, DS_DUP, DS_OVER: begin
                // NOS spills to memory only when it holds a real item.
                if (depth >= DW'(2)) begin
                  ss_op_d = SS_PUSH;
                  ss_vi_d = nos;
                end
                nos_d = tos;
                if (cmd_op == DS_LIT)       tos_d = cmd_val;
                else if (cmd_op == DS_OVER) tos_d = nos;
              end
              DS_SWAP: begin
                tos_d = nos;
                nos_d = tos;
              end
              DS_DROP, DS_ADD, DS_SUB, DS_AND: begin
                tos_d = alu_c;
                if (depth >= DW'(3)) begin
                  ss_op_d = SS_POP;
                  state_d = ST_FILL;
                  ready_d = 1'b0;
                  lat_d   = '0;
                end else begin
                  nos_d = '0;
                end
              end
              DS_ROT: begin
                ss_op_d = SS_POP;
                state_d = ST_ROT_W;
                ready_d = 1'b0;
                lat_d   = '0;
              end
              default: ;
            endcase
          end
        end
      end

      ST_FILL: begin
        lat_d = lat_q + LW'(1);
        if (data_rdy_c) begin
          nos_d   = ss_s;
          state_d = ST_IDLE;
          ready_d = 1'b1;
        end
      end

      // a b c -- b c a : popped a becomes TOS, old NOS b goes back to memory.
      ST_ROT_W: begin
        lat_d = lat_q + LW'(1);
        if (data_rdy_c) begin
          tos_d   = ss_s;
          nos_d   = tos;
          ss_op_d = SS_PUSH;
          ss_vi_d = nos;
          state_d = ST_ROT_P;
        end
      end

      ST_ROT_P: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      lat_q     <= '0;
      tos       <= '0;
      nos       <= '0;
      depth     <= '0;
      cmd_ready <= 1'b1;
      ss_op     <= SS_NOP;
      ss_vi     <= '0;
      err_under <= 1'b0;
      err_over  <= 1'b0;
    end else begin
      state_q   <= state_d;
      lat_q     <= lat_d;
      tos       <= tos_d;
      nos       <= nos_d;
      depth     <= depth_d;
      cmd_ready <= ready_d;
      ss_op     <= ss_op_d;
      ss_vi     <= ss_vi_d;
      err_under <= under_d;
      err_over  <= over_d;
    end
  end

endmodule

// File: tb/tb_ds_tos_cache.sv
// Bench for ds_tos_cache: stack-memory model on the ss bus, whole-stack
// queue reference model, directed scenarios then randomized primitives.
module tb_ds_tos_cache;
  import forthsuper_pkg::*;

  localparam int unsigned DSZ    = 32;
  localparam int unsigned DEPTH  = 64;
  localparam int unsigned RD_LAT = 1;
  localparam int unsigned DW     = $clog2(DEPTH + 3);
  localparam int          CAP    = DEPTH + 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           cmd_valid;
  logic           cmd_ready;
  ds_op_t         cmd_op;
  logic [DSZ-1:0] cmd_val;
  logic [DSZ-1:0] tos, nos;
  logic [DW-1:0]  depth;
  logic           err_under, err_over;
  stack_ops       ss_op;
  logic [DSZ-1:0] ss_vi, ss_s;

  always #5 clk = ~clk;

  ds_tos_cache #(.DSZ(DSZ), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_val(cmd_val), .tos(tos), .nos(nos), .depth(depth),
    .err_under(err_under), .err_over(err_over), .ss_op(ss_op), .ss_vi(ss_vi),
    .ss_s(ss_s)
  );

  // Stack memory: synchronous pop with an RD_LAT-deep read pipeline.
  logic [DSZ-1:0] mem [DEPTH];
  logic [DSZ-1:0] rd_pipe [RD_LAT];
  int             sp;
  assign ss_s = rd_pipe[RD_LAT-1];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sp <= 0;
      for (int k = 0; k < int'(RD_LAT); k++) rd_pipe[k] <= '0;
    end else begin
      if (ss_op == SS_PUSH && sp < int'(DEPTH)) begin
        mem[sp] <= ss_vi;
        sp      <= sp + 1;
      end else if (ss_op == SS_POP && sp > 0) begin
        rd_pipe[0] <= mem[sp-1];
        sp         <= sp - 1;
      end
      for (int k = 1; k < int'(RD_LAT); k++) rd_pipe[k] <= rd_pipe[k-1];
    end
  end

  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: full stack contents, index 0 is the top.
  logic [DSZ-1:0] stk [$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int need_of(input ds_op_t op);
    case (op)
      DS_DUP, DS_DROP:                          return 1;
      DS_SWAP, DS_OVER, DS_ADD, DS_SUB, DS_AND: return 2;
      DS_ROT:                                   return 3;
      default:                                  return 0;
    endcase
  endfunction

  function automatic bit grows(input ds_op_t op);
    return (op == DS_LIT || op == DS_DUP || op == DS_OVER);
  endfunction

  task automatic cmd_idle();
    cmd_valid = 1'b0;
    cmd_op    = DS_NOP;
  endtask

  task automatic do_reset();
    cmd_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    stk.delete();
  endtask

  // Offer one primitive, check its effects against the queue model.
  task automatic run_cmd(input ds_op_t op, input logic [DSZ-1:0] val);
    int             d, guard, low, pushes, exp_lat;
    bit             under, over, acc;
    stack_ops       exp_op;
    logic [DSZ-1:0] exp_vi, t, n, a;

    d      = stk.size();
    under  = d < need_of(op);
    over   = !under && grows(op) && d == CAP;
    acc    = !under && !over && op != DS_NOP;
    exp_op = SS_NOP;
    exp_vi = (d >= 2) ? stk[1] : '0;
    exp_lat = 0;
    if (acc) begin
      if (grows(op) && d >= 2) exp_op = SS_PUSH;
      if (op == DS_ROT) begin
        exp_op  = SS_POP;
        exp_lat = 2 + int'(RD_LAT);
      end else if (need_of(op) >= 1 && !grows(op) && op != DS_SWAP && d >= 3) begin
        exp_op  = SS_POP;
        exp_lat = 1 + int'(RD_LAT);
      end
      case (op)
        DS_LIT:  stk.push_front(val);
        DS_DUP:  stk.push_front(stk[0]);
        DS_OVER: stk.push_front(stk[1]);
        DS_DROP: void'(stk.pop_front());
        DS_SWAP: begin t = stk[0]; stk[0] = stk[1]; stk[1] = t; end
        DS_ROT:  begin a = stk[2]; stk[2] = stk[1]; stk[1] = stk[0]; stk[0] = a; end
        default: begin
          t = stk.pop_front();
          n = stk.pop_front();
          if (op == DS_ADD)      stk.push_front(n + t);
          else if (op == DS_SUB) stk.push_front(n - t);
          else                   stk.push_front(n & t);
        end
      endcase
    end

    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_val   = val;
    guard     = 0;
    while (!cmd_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!cmd_ready) check("ready_timeout", 64'(cmd_ready), 64'd1);
    @(posedge clk); #1;

    check("err_under", 64'(err_under), 64'(under));
    check("err_over", 64'(err_over), 64'(over));
    check("depth", 64'(depth), 64'(stk.size()));
    check("ss_op", 64'(ss_op), 64'(exp_op));
    if (exp_op == SS_PUSH) check("ss_vi", 64'(ss_vi), 64'(exp_vi));

    low    = 0;
    pushes = 0;
    while (!cmd_ready && low < 50) begin
      @(posedge clk); #1;
      low++;
      if (ss_op == SS_PUSH) begin
        pushes++;
        check("rot_push_vi", 64'(ss_vi), 64'(exp_vi));
      end
    end
    if (exp_lat != 0 || low != 0) check("stall_cycles", 64'(low), 64'(exp_lat));
    if (op == DS_ROT && acc) check("rot_pushes", 64'(pushes), 64'd1);

    if (stk.size() >= 1) check("tos", 64'(tos), 64'(stk[0]));
    if (stk.size() >= 2) check("nos", 64'(nos), 64'(stk[1]));
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_tos"}, 64'(tos), 64'd0);
    check({tag, "_nos"}, 64'(nos), 64'd0);
    check({tag, "_depth"}, 64'(depth), 64'd0);
    check({tag, "_ready"}, 64'(cmd_ready), 64'd1);
    check({tag, "_ss_op"}, 64'(ss_op), 64'(SS_NOP));
    check({tag, "_ss_vi"}, 64'(ss_vi), 64'd0);
    check({tag, "_errs"}, 64'({err_under, err_over}), 64'd0);
  endtask

  initial begin
    int c0;
    ds_op_t op;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = DS_NOP;
    cmd_val = '0;
    cyc = 0;
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0;

    // LIT 5,7,9 then ADD with refill.
    run_cmd(DS_LIT, 32'd5);
    run_cmd(DS_LIT, 32'd7);
    run_cmd(DS_LIT, 32'd9);
    run_cmd(DS_ADD, 32'd0);
    check("add_tos16", 64'(tos), 64'd16);
    check("add_nos5", 64'(nos), 64'd5);

    // ROT then DROP,DROP exposes memory top.
    do_reset();
    run_cmd(DS_LIT, 32'd1);
    run_cmd(DS_LIT, 32'd2);
    run_cmd(DS_LIT, 32'd3);
    run_cmd(DS_ROT, 32'd0);
    run_cmd(DS_DROP, 32'd0);
    run_cmd(DS_DROP, 32'd0);
    check("rot_drop_tos2", 64'(tos), 64'd2);

    // Underflow on empty, then fill to capacity and overflow.
    do_reset();
    run_cmd(DS_DROP, 32'd0);
    cmd_idle();
    @(posedge clk); #1;
    check("under_pulse_end", 64'(err_under), 64'd0);
    for (int i = 0; i < CAP; i++) run_cmd(DS_LIT, 32'(i + 100));
    run_cmd(DS_DUP, 32'd0);
    run_cmd(DS_LIT, 32'hdead);

    // Back-to-back single-cycle ops with valid held.
    do_reset();
    run_cmd(DS_LIT, 32'd11);
    run_cmd(DS_LIT, 32'd22);
    run_cmd(DS_LIT, 32'd33);
    c0 = cyc;
    run_cmd(DS_SWAP, 32'd0);
    run_cmd(DS_OVER, 32'd0);
    run_cmd(DS_DUP, 32'd0);
    check("b2b_cycles", 64'(cyc - c0), 64'd3);

    // Reset while waiting for the ROT pop.
    do_reset();
    run_cmd(DS_LIT, 32'd1);
    run_cmd(DS_LIT, 32'd2);
    run_cmd(DS_LIT, 32'd3);
    cmd_op = DS_ROT;
    @(posedge clk); #1;
    check("rotw_ready_low", 64'(cmd_ready), 64'd0);
    rst = 1'b1;
    cmd_idle();
    @(posedge clk); #1;
    check_reset("midrot");
    rst = 1'b0;
    stk.delete();
    run_cmd(DS_LIT, 32'd4);
    check("after_rst_tos4", 64'(tos), 64'd4);

    // Randomized primitives against the model.
    for (int i = 0; i < 500; i++) begin
      op = ds_op_t'(4'($urandom_range(0, 9)));
      if (stk.size() < 4 && $urandom_range(0, 1) == 1) op = DS_LIT;
      run_cmd(op, $urandom());
    end
    cmd_idle();
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
